// File: rtl/systolic_matmul_stream.sv
// N x N output-stationary systolic matrix multiplier with internal operand skew and row-wise result streaming.
// Define SYSTOLIC_SIGNED_EN for two's-complement operands; otherwise operands are unsigned.
module systolic_matmul_stream #(
    parameter int ARRAY_SIZE = 4,
    parameter int DW_IN      = 8,
    parameter int K_MAX      = 16,
    parameter int DW_OUT     = 2*DW_IN+$clog2(K_MAX)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_last,
    input  logic [ARRAY_SIZE*DW_IN-1:0]  a_col,
    input  logic [ARRAY_SIZE*DW_IN-1:0]  b_row,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ARRAY_SIZE*DW_OUT-1:0] out_row,
    output logic                         out_last,
    output logic                         overrun
);

    localparam int N         = ARRAY_SIZE;
    localparam int FLUSH_LEN = 2*N-2;
    localparam int FW        = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
    localparam int RW        = (N > 1) ? $clog2(N) : 1;
    localparam int CW        = (K_MAX > 1) ? $clog2(K_MAX) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, OUTPUT} state_t;

    state_t          state, state_next;
    logic [FW-1:0]   flush_cnt;
    logic [CW-1:0]   beat_cnt;
    logic [RW-1:0]   row_cnt, row_sel;
    logic            accept, advance, inject_zero, done, last_beat;
    logic [N*DW_OUT-1:0] row_word;

    logic [DW_IN-1:0]  a_edge [N];
    logic [DW_IN-1:0]  b_edge [N];
    logic [DW_IN-1:0]  a_pe   [N][N];
    logic [DW_IN-1:0]  b_pe   [N][N];
    logic [DW_OUT-1:0] acc    [N][N];

    function automatic logic [DW_OUT-1:0] mul(input logic [DW_IN-1:0] x, input logic [DW_IN-1:0] y);
`ifdef SYSTOLIC_SIGNED_EN
        logic signed [2*DW_IN-1:0] p;
        p = $signed({{DW_IN{x[DW_IN-1]}}, x}) * $signed({{DW_IN{y[DW_IN-1]}}, y});
        return DW_OUT'(p);
`else
        logic [2*DW_IN-1:0] p;
        p = {{DW_IN{1'b0}}, x} * {{DW_IN{1'b0}}, y};
        return DW_OUT'(p);
`endif
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // A job ends its load phase on in_last or when K_MAX beats have arrived.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE, LOAD: begin
                if (accept) begin
                    if (last_beat) state_next = (FLUSH_LEN == 0) ? OUTPUT : FLUSH;
                    else           state_next = LOAD;
                end
            end
            FLUSH:   if (flush_cnt == FW'(FLUSH_LEN-1)) state_next = OUTPUT;
            OUTPUT:  if (done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready    = (state == IDLE) || (state == LOAD);
        accept      = in_valid && in_ready;
        inject_zero = (state == FLUSH);
        advance     = accept || inject_zero;
        last_beat   = in_last || (beat_cnt == CW'(K_MAX-1));
        done        = (state == OUTPUT) && out_valid && out_ready && (row_cnt == RW'(N-1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt <= '0;
            beat_cnt  <= '0;
            overrun   <= 1'b0;
        end else begin
            flush_cnt <= (state == FLUSH && state_next == FLUSH) ? flush_cnt + FW'(1) : '0;
            overrun   <= accept && !in_last && (beat_cnt == CW'(K_MAX-1));
            if (done)
                beat_cnt <= '0;
            else if (accept && !last_beat)
                beat_cnt <= beat_cnt + CW'(1);
        end
    end

    genvar i, j;
    for (i = 0; i < N; i++) begin : g_skew
        logic [DW_IN-1:0] a_src, b_src;
        assign a_src = inject_zero ? '0 : a_col[i*DW_IN +: DW_IN];
        assign b_src = inject_zero ? '0 : b_row[i*DW_IN +: DW_IN];
        if (i == 0) begin : g_direct
            assign a_edge[i] = a_src;
            assign b_edge[i] = b_src;
        end else begin : g_delay
            // Row/column i is held back by i array advances so operands meet in step.
            logic [DW_IN-1:0] a_sr [i];
            logic [DW_IN-1:0] b_sr [i];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n || done) begin
                    for (int s = 0; s < i; s++) begin
                        a_sr[s] <= '0;
                        b_sr[s] <= '0;
                    end
                end else if (advance) begin
                    a_sr[0] <= a_src;
                    b_sr[0] <= b_src;
                    for (int s = 1; s < i; s++) begin
                        a_sr[s] <= a_sr[s-1];
                        b_sr[s] <= b_sr[s-1];
                    end
                end
            end
            assign a_edge[i] = a_sr[i-1];
            assign b_edge[i] = b_sr[i-1];
        end
    end

    for (i = 0; i < N; i++) begin : g_row
        for (j = 0; j < N; j++) begin : g_col
            logic [DW_IN-1:0]  a_in, b_in, a_q, b_q;
            logic [DW_OUT-1:0] acc_q;
            if (j == 0) begin : g_a_edge
                assign a_in = a_edge[i];
            end else begin : g_a_pe
                assign a_in = a_pe[i][j-1];
            end
            if (i == 0) begin : g_b_edge
                assign b_in = b_edge[j];
            end else begin : g_b_pe
                assign b_in = b_pe[i-1][j];
            end
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n || done) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    acc_q <= '0;
                end else if (advance) begin
                    a_q   <= a_in;
                    b_q   <= b_in;
                    acc_q <= acc_q + mul(a_in, b_in);
                end
            end
            assign a_pe[i][j] = a_q;
            assign b_pe[i][j] = b_q;
            assign acc[i][j]  = acc_q;
        end
    end

    // The first OUTPUT cycle loads row 0; later rows load on each downstream handshake.
    always_comb begin
        row_sel = (out_valid && row_cnt != RW'(N-1)) ? row_cnt + RW'(1) : '0;
        row_word = '0;
        for (int c = 0; c < N; c++)
            row_word[c*DW_OUT +: DW_OUT] = acc[row_sel][c];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_row   <= '0;
            out_last  <= 1'b0;
            row_cnt   <= '0;
        end else if (state == OUTPUT) begin
            if (!out_valid || (out_ready && row_cnt != RW'(N-1))) begin
                out_valid <= 1'b1;
                out_row   <= row_word;
                out_last  <= (row_sel == RW'(N-1));
                row_cnt   <= row_sel;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_row   <= '0;
                out_last  <= 1'b0;
                row_cnt   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_systolic_matmul_stream.sv
// Scoreboard bench for systolic_matmul_stream: directed jobs push expected rows, a monitor pops and compares.
module tb_systolic_matmul_stream;

    localparam int N      = 4;
    localparam int DW_IN  = 8;
    localparam int K_MAX  = 16;
    localparam int DW_OUT = 2*DW_IN+$clog2(K_MAX);

    typedef struct {
        logic [N*DW_OUT-1:0] row;
        bit                  last;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  in_valid, in_ready, in_last;
    logic [N*DW_IN-1:0]    a_col, b_row;
    logic                  out_valid, out_ready, out_last, overrun;
    logic [N*DW_OUT-1:0]   out_row;

    exp_t                  sb[$];
    logic [DW_IN-1:0]      a_mat [N][K_MAX];
    logic [DW_IN-1:0]      b_mat [K_MAX][N];
    int                    checks = 0;
    int                    errors = 0;
    int                    cyc = 0;
    logic [N*DW_OUT-1:0]   held_row;
    bit                    held_valid = 0;
    bit                    ready_chk = 0;

    systolic_matmul_stream #(.ARRAY_SIZE(N), .DW_IN(DW_IN), .K_MAX(K_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .a_col(a_col), .b_row(b_row), .out_valid(out_valid), .out_ready(out_ready),
        .out_row(out_row), .out_last(out_last), .overrun(overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_row(input int c0, input int c1, input int c2, input int c3, input bit last);
        exp_t e;
        e.row = {DW_OUT'(c3), DW_OUT'(c2), DW_OUT'(c1), DW_OUT'(c0)};
        e.last = last;
        sb.push_back(e);
    endtask

    task automatic push_identity();
        push_row(1, 2, 3, 4, 0);
        push_row(5, 6, 7, 8, 0);
        push_row(9, 10, 11, 12, 0);
        push_row(13, 14, 15, 16, 1);
    endtask

    task automatic fill(input bit identity, input logic [DW_IN-1:0] av, input logic [DW_IN-1:0] bv);
        for (int i = 0; i < N; i++)
            for (int k = 0; k < K_MAX; k++) begin
                a_mat[i][k] = identity ? DW_IN'(i == k) : av;
                b_mat[k][i] = identity ? DW_IN'(4*k+i+1) : bv;
            end
    endtask

    // Sends k beats; optionally stalls before beat gap_at and checks the overrun pulse.
    task automatic apply_stimulus(input int k, input int gap_at, input int gap_len, input bit use_last,
                                  output int first_cyc);
        for (int t = 0; t < k; t++) begin
            if (t == gap_at) begin
                repeat (gap_len) @(posedge clk);
                #1;
            end
            for (int i = 0; i < N; i++) begin
                a_col[i*DW_IN +: DW_IN] = a_mat[i][t];
                b_row[i*DW_IN +: DW_IN] = b_mat[t][i];
            end
            in_last  = use_last && (t == k-1);
            in_valid = 1'b1;
            for (int w = 0; w <= 50; w++) begin
                @(negedge clk);
                if (in_ready) break;
                if (w == 50) begin
                    $display("[TB] FAIL in_ready_timeout actual=0 required=1");
                    $fatal(1, "[TB] stuck");
                end
            end
            @(posedge clk);
            #1;
            if (t == 0) first_cyc = cyc;
            in_valid = 1'b0;
            in_last  = 1'b0;
            if (!use_last && t >= k-2) check_output($sformatf("overrun_beat%0d", t+1), overrun, t == K_MAX-1);
        end
        if (!use_last) begin
            @(posedge clk);
            #1;
            check_output("overrun_single_pulse", overrun, 0);
        end
    endtask

    task automatic wait_first_valid(input int first_cyc, input int exp_lat, input string name);
        for (int w = 0; w < 100; w++) begin
            @(negedge clk);
            if (out_valid) begin
                check_output(name, cyc - first_cyc, exp_lat);
                return;
            end
        end
        check_output({name, "_timeout"}, 0, 1);
    endtask

    task automatic wait_drain();
        for (int w = 0; w < 200 && sb.size() != 0; w++) @(negedge clk);
        check_output("rows_outstanding", sb.size(), 0);
        sb.delete();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops on each row handshake and watches stalls, busy in_ready and release of in_ready.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            held_valid = 0;
            ready_chk  = 0;
        end else begin
            if (ready_chk) begin
                check_output("in_ready_after_last", in_ready, 1);
                ready_chk = 0;
            end
            if (out_valid) begin
                check_output("in_ready_busy", in_ready, 0);
                if (held_valid) check_output("row_held", out_row, held_row);
                if (out_ready) begin
                    held_valid = 0;
                    if (sb.size() == 0) begin
                        check_output("unexpected_row", out_row, 0);
                        check_output("unexpected_row_valid", out_valid, 0);
                    end else begin
                        e = sb.pop_front();
                        check_output("out_row", out_row, e.row);
                        check_output("out_last", out_last, e.last);
                        if (e.last) ready_chk = 1;
                    end
                end else begin
                    held_row   = out_row;
                    held_valid = 1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int f;
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; a_col = '0; b_row = '0; out_ready = 1'b1;
        #2;
        check_output("rst_in_ready", in_ready, 1);
        check_output("rst_out_valid", out_valid, 0);
        check_output("rst_out_row", out_row, 0);
        check_output("rst_out_last", out_last, 0);
        check_output("rst_overrun", overrun, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] identity job");
        fill(1, 0, 0);
        push_identity();
        apply_stimulus(4, -1, 0, 1, f);
        wait_first_valid(f, 10, "lat_identity");
        wait_drain();

        $display("[TB] all FF x 02 job");
        fill(0, 8'hFF, 8'h02);
`ifdef SYSTOLIC_SIGNED_EN
        for (int r = 0; r < N; r++) push_row(-8, -8, -8, -8, r == N-1);
`else
        for (int r = 0; r < N; r++) push_row(2040, 2040, 2040, 2040, r == N-1);
`endif
        apply_stimulus(4, -1, 0, 1, f);
        wait_first_valid(f, 10, "lat_ffx02");
        wait_drain();

        $display("[TB] stalled identity job");
        fill(1, 0, 0);
        push_identity();
        apply_stimulus(4, 2, 3, 1, f);
        wait_first_valid(f, 13, "lat_stall");
        wait_drain();

        $display("[TB] backpressure on row 1");
        push_identity();
        apply_stimulus(4, -1, 0, 1, f);
        wait_first_valid(f, 10, "lat_backpressure");
        @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
        wait_drain();

        $display("[TB] overrun job");
        fill(0, 8'h01, 8'h01);
        for (int r = 0; r < N; r++) push_row(16, 16, 16, 16, r == N-1);
        apply_stimulus(16, -1, 0, 0, f);
        wait_first_valid(f, 22, "lat_overrun");
        wait_drain();

        $display("[TB] reset during flush");
        fill(1, 0, 0);
        apply_stimulus(4, -1, 0, 1, f);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_output("midrst_in_ready", in_ready, 1);
        check_output("midrst_out_valid", out_valid, 0);
        check_output("midrst_out_row", out_row, 0);
        check_output("midrst_out_last", out_last, 0);
        check_output("midrst_overrun", overrun, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check_output("midrst_no_output", out_valid, 0);
        @(posedge clk);
        #1;
        push_identity();
        apply_stimulus(4, -1, 0, 1, f);
        wait_first_valid(f, 10, "lat_after_reset");
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
